// File: rtl/dht_pkg.sv
// Shared types and helpers for the humidity/temperature sensor measurement scheduler.
package dht_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HOLDOFF = 3'd1,
    S_TRIG    = 3'd2,
    S_WAIT    = 3'd3,
    S_CHECK   = 3'd4
  } dht_state_e;

  typedef enum logic [1:0] {
    ST_NONE = 2'b00,
    ST_OK   = 2'b01,
    ST_CHK  = 2'b10,
    ST_TMO  = 2'b11
  } dht_stat_e;

  // Frame checksum: plain 8-bit wrapping sum of the four data bytes.
  function automatic logic [7:0] dht_chksum(input logic [7:0] h, input logic [7:0] hd,
                                            input logic [7:0] t, input logic [7:0] td);
    return h + hd + t + td;
  endfunction

  function automatic logic [1:0] dht_sat2(input logic [7:0] v);
    return (v > 8'd3) ? 2'd3 : v[1:0];
  endfunction

endpackage

// File: rtl/cyc_timer.sv
// Loadable down-counter that stops at zero; zero flag is a direct decode of the count.
module cyc_timer #(
  parameter int unsigned          CNT_W   = 32,
  parameter logic [CNT_W-1:0]     RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  input  logic             i_en,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= RST_VAL;
    else if (i_load)
      r_cnt <= i_value;
    else if (i_en && (r_cnt != '0))
      r_cnt <= r_cnt - CNT_W'(1);
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/dht_meas_sched.sv
// Measurement scheduler for the one-wire sensor core: hold-off, trigger, timeout,
// checksum validation, automatic retry and last-good-sample storage.
module dht_meas_sched
  import dht_pkg::*;
#(
  parameter int unsigned MIN_GAP_CYC = 100_000_000,
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             auto_en_i,
  input  logic [CNT_W-1:0] period_i,
  output logic             measure_o,
  input  logic             done_i,
  input  logic [7:0]       hum_i,
  input  logic [7:0]       humd_i,
  input  logic [7:0]       tem_i,
  input  logic [7:0]       temd_i,
  input  logic [7:0]       sum_i,
  output logic [7:0]       hum_o,
  output logic [7:0]       humd_o,
  output logic [7:0]       tem_o,
  output logic [7:0]       temd_o,
  output logic             valid_o,
  output logic             ready_o,
  output logic [1:0]       stat_o,
  output logic [1:0]       retries_o,
  output logic             evt_o
);

  localparam logic [CNT_W-1:0] GAP  = CNT_W'(MIN_GAP_CYC);
  localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT_CYC);
  localparam logic [7:0]       RMAX = 8'(MAX_RETRY);

  dht_state_e r_state, w_nxt;
  dht_stat_e  r_stat, w_fail_code;
  logic       r_pend, r_retry_act, r_auto_run, r_meas, r_evt, r_valid;
  logic [7:0] r_rcnt;
  logic [1:0] r_retries;
  logic [7:0] r_hum, r_humd, r_tem, r_temd, r_sum;
  logic [7:0] r_hum_o, r_humd_o, r_tem_o, r_temd_o;

  logic             w_gap_zero, w_tmo_zero, w_auto_zero;
  logic             w_gap_load, w_ok, w_fail, w_auto_tick, w_auto_load;
  logic [CNT_W-1:0] w_eff_period, w_auto_val;

  assign w_eff_period = (period_i < GAP) ? GAP : period_i;
  // Reload with period-1 so consecutive ticks are exactly one effective period apart.
  assign w_auto_tick  = auto_en_i && r_auto_run && w_auto_zero;
  assign w_auto_load  = !auto_en_i || !r_auto_run || w_auto_zero;
  assign w_auto_val   = auto_en_i ? (w_eff_period - CNT_W'(1)) : '0;

  cyc_timer #(.CNT_W(CNT_W), .RST_VAL(GAP)) u_gap (
    .clk(clk), .rst_n(reset), .i_load(w_gap_load), .i_value(GAP),
    .i_en(r_state == S_HOLDOFF), .o_zero(w_gap_zero));

  cyc_timer #(.CNT_W(CNT_W), .RST_VAL('0)) u_tmo (
    .clk(clk), .rst_n(reset), .i_load(r_state == S_TRIG), .i_value(TMO),
    .i_en(r_state == S_WAIT), .o_zero(w_tmo_zero));

  cyc_timer #(.CNT_W(CNT_W), .RST_VAL('0)) u_auto (
    .clk(clk), .rst_n(reset), .i_load(w_auto_load), .i_value(w_auto_val),
    .i_en(auto_en_i), .o_zero(w_auto_zero));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_HOLDOFF;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt       = r_state;
    w_gap_load  = 1'b0;
    w_ok        = 1'b0;
    w_fail      = 1'b0;
    w_fail_code = ST_TMO;
    case (r_state)
      S_IDLE:    if (r_pend) w_nxt = S_HOLDOFF;
      S_HOLDOFF: if (w_gap_zero) w_nxt = (r_pend || r_retry_act) ? S_TRIG : S_IDLE;
      S_TRIG:    w_nxt = S_WAIT;
      S_WAIT: begin
        if (done_i) begin
          w_nxt = S_CHECK;
        end else if (w_tmo_zero) begin
          w_fail     = 1'b1;
          w_gap_load = 1'b1;
          w_nxt      = S_HOLDOFF;
        end
      end
      S_CHECK: begin
        w_gap_load = 1'b1;
        w_nxt      = S_HOLDOFF;
        if (dht_chksum(r_hum, r_humd, r_tem, r_temd) == r_sum) begin
          w_ok = 1'b1;
        end else begin
          w_fail      = 1'b1;
          w_fail_code = ST_CHK;
        end
      end
      default:   w_nxt = S_HOLDOFF;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend      <= 1'b0;
      r_retry_act <= 1'b0;
      r_auto_run  <= 1'b0;
      r_meas      <= 1'b0;
      r_evt       <= 1'b0;
      r_valid     <= 1'b0;
      r_stat      <= ST_NONE;
      r_retries   <= '0;
      r_rcnt      <= '0;
      {r_hum, r_humd, r_tem, r_temd, r_sum} <= '0;
      {r_hum_o, r_humd_o, r_tem_o, r_temd_o} <= '0;
    end else begin
      r_meas     <= (w_nxt == S_TRIG);
      r_evt      <= 1'b0;
      r_auto_run <= auto_en_i;
      // Requests during an in-flight attempt fold into it; the CHECK cycle is not in-flight.
      if (r_state == S_TRIG)
        r_pend <= 1'b0;
      else if ((start_i || w_auto_tick) && (r_state != S_WAIT))
        r_pend <= 1'b1;
      if (r_state == S_TRIG)
        r_retry_act <= 1'b0;
      if ((r_state == S_WAIT) && done_i)
        {r_hum, r_humd, r_tem, r_temd, r_sum} <= {hum_i, humd_i, tem_i, temd_i, sum_i};
      if (w_ok) begin
        {r_hum_o, r_humd_o, r_tem_o, r_temd_o} <= {r_hum, r_humd, r_tem, r_temd};
        r_valid     <= 1'b1;
        r_stat      <= ST_OK;
        r_evt       <= 1'b1;
        r_retries   <= dht_sat2(r_rcnt);
        r_rcnt      <= '0;
        r_retry_act <= 1'b0;
      end else if (w_fail) begin
        r_stat <= w_fail_code;
        if (r_rcnt < RMAX) begin
          r_rcnt      <= r_rcnt + 8'd1;
          r_retry_act <= 1'b1;
        end else begin
          r_evt       <= 1'b1;
          r_retries   <= dht_sat2(r_rcnt);
          r_rcnt      <= '0;
          r_retry_act <= 1'b0;
        end
      end
    end
  end

  assign measure_o = r_meas;
  assign evt_o     = r_evt;
  assign valid_o   = r_valid;
  assign stat_o    = r_stat;
  assign retries_o = r_retries;
  assign ready_o   = (r_state == S_IDLE);
  assign hum_o     = r_hum_o;
  assign humd_o    = r_humd_o;
  assign tem_o     = r_tem_o;
  assign temd_o    = r_temd_o;

endmodule

// File: tb/tb_dht_meas_sched.sv
// Directed bench for dht_meas_sched with a short hold-off (100) and timeout (50).
module tb_dht_meas_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_i = 1'b0, auto_en_i = 1'b0, done_i = 1'b0;
  logic [31:0] period_i = '0;
  logic [7:0]  hum_i = '0, humd_i = '0, tem_i = '0, temd_i = '0, sum_i = '0;
  logic        measure_o, valid_o, ready_o, evt_o;
  logic [7:0]  hum_o, humd_o, tem_o, temd_o;
  logic [1:0]  stat_o, retries_o;

  int n_chk = 0, n_err = 0;
  int cyc = 0, meas_cnt = 0, evt_cnt = 0, last_meas = 0;

  dht_meas_sched #(.MIN_GAP_CYC(100), .TIMEOUT_CYC(50), .MAX_RETRY(2), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .auto_en_i(auto_en_i), .period_i(period_i),
    .measure_o(measure_o), .done_i(done_i), .hum_i(hum_i), .humd_i(humd_i), .tem_i(tem_i),
    .temd_i(temd_i), .sum_i(sum_i), .hum_o(hum_o), .humd_o(humd_o), .tem_o(tem_o),
    .temd_o(temd_o), .valid_o(valid_o), .ready_o(ready_o), .stat_o(stat_o),
    .retries_o(retries_o), .evt_o(evt_o));

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (measure_o) begin
      meas_cnt  = meas_cnt + 1;
      last_meas = cyc;
    end
    if (evt_o) evt_cnt = evt_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic wait_meas(input int bound, output bit got);
    int base;
    base = meas_cnt;
    got  = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk); #1;
      if (meas_cnt != base) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] h, input logic [7:0] hd, input logic [7:0] t,
                            input logic [7:0] td, input logic [7:0] s);
    @(negedge clk);
    {hum_i, humd_i, tem_i, temd_i, sum_i} = {h, hd, t, td, s};
    done_i = 1'b1;
    @(negedge clk);
    done_i = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish got 0 expected 1");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int m1, m2, m3, e0, c0;

    // Reset values
    idle(3);
    check("rst_measure", measure_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_stat", stat_o, 0);
    check("rst_ready", ready_o, 0);
    check("rst_hum", {hum_o, humd_o, tem_o, temd_o}, 0);
    @(negedge clk); reset = 1'b1;

    // 1: start at cycle 10, first trigger only after full hold-off
    repeat (9) @(negedge clk);
    start_i = 1'b1; @(negedge clk); start_i = 1'b0;
    wait_meas(300, got);
    check("t1_meas_seen", got, 1);
    check("t1_not_before_100", last_meas >= 100, 1);
    @(negedge clk); #1;
    check("t1_pulse_width", measure_o, 0);

    // 2: good frame
    send_frame(8'd40, 8'd0, 8'd25, 8'd0, 8'd65);
    idle(3);
    check("t2_hum", hum_o, 40);
    check("t2_tem", tem_o, 25);
    check("t2_humd_temd", {humd_o, temd_o}, 0);
    check("t2_valid", valid_o, 1);
    check("t2_stat", stat_o, 1);
    check("t2_retries", retries_o, 0);
    check("t2_evt", evt_cnt, 1);
    check("t2_ready_busy", ready_o, 0);
    idle(110);
    check("t2_ready_idle", ready_o, 1);
    check("t2_one_pulse", meas_cnt, 1);

    // 3: checksum failure on every attempt
    e0 = evt_cnt; c0 = meas_cnt;
    pulse_start();
    wait_meas(300, got); m1 = last_meas;
    check("t3_meas1", got, 1);
    send_frame(8'd40, 8'd0, 8'd25, 8'd0, 8'd66);
    idle(4);
    check("t3_stat_mid", stat_o, 2);
    check("t3_no_evt_mid", evt_cnt - e0, 0);
    wait_meas(300, got); m2 = last_meas;
    check("t3_meas2", got, 1);
    send_frame(8'd11, 8'd22, 8'd33, 8'd44, 8'd0);
    wait_meas(300, got); m3 = last_meas;
    check("t3_meas3", got, 1);
    send_frame(8'd11, 8'd22, 8'd33, 8'd44, 8'd111);
    idle(4);
    check("t3_gap12", (m2 - m1) >= 100, 1);
    check("t3_gap23", (m3 - m2) >= 100, 1);
    check("t3_evt_once", evt_cnt - e0, 1);
    check("t3_stat", stat_o, 2);
    check("t3_retries", retries_o, 2);
    check("t3_hum_kept", hum_o, 40);
    check("t3_valid_kept", valid_o, 1);
    wait_meas(150, got);
    check("t3_no_4th", meas_cnt - c0, 3);

    // 4a: timeout then good retry
    e0 = evt_cnt;
    pulse_start();
    wait_meas(300, got); m1 = last_meas;
    check("t4_meas1", got, 1);
    idle(70);
    check("t4_stat_tmo", stat_o, 3);
    check("t4_no_evt", evt_cnt - e0, 0);
    wait_meas(200, got); m2 = last_meas;
    check("t4_retry_meas", got, 1);
    check("t4_retry_gap", (m2 - m1) >= 150, 1);
    send_frame(8'd1, 8'd2, 8'd3, 8'd4, 8'd10);
    idle(4);
    check("t4_stat_ok", stat_o, 1);
    check("t4_retries", retries_o, 1);
    check("t4_hum", hum_o, 1);
    check("t4_temd", temd_o, 4);
    check("t4_evt", evt_cnt - e0, 1);

    // 4b: done one cycle after expiry is ignored; done on the expiry cycle counts
    idle(110);
    pulse_start();
    wait_meas(300, got);
    check("t4b_meas1", got, 1);
    repeat (51) @(negedge clk);
    send_frame(8'd5, 8'd5, 8'd5, 8'd5, 8'd20);
    idle(5);
    check("t4b_late_tmo", stat_o, 3);
    check("t4b_late_hum", hum_o, 1);
    wait_meas(200, got);
    check("t4b_meas2", got, 1);
    repeat (50) @(negedge clk);
    send_frame(8'd6, 8'd6, 8'd6, 8'd6, 8'd24);
    idle(4);
    check("t4b_edge_ok", stat_o, 1);
    check("t4b_edge_hum", hum_o, 6);
    check("t4b_edge_retries", retries_o, 1);

    // 5: periodic mode with a short period, extra starts during WAIT
    idle(110);
    period_i  = 32'd30;
    auto_en_i = 1'b1;
    m1 = 0;
    for (int k = 0; k < 3; k++) begin
      wait_meas(300, got);
      check("t5_meas", got, 1);
      if (k > 0) check("t5_gap", (last_meas - m1) >= 100, 1);
      m1 = last_meas;
      pulse_start();
      send_frame(8'd7, 8'd0, 8'd8, 8'd0, 8'd15);
    end
    auto_en_i = 1'b0;
    wait_meas(250, got);
    if (got) send_frame(8'd7, 8'd0, 8'd8, 8'd0, 8'd15);
    idle(110);
    wait_meas(200, got);
    check("t5_quiet_after_disable", got, 0);
    check("t5_hum", hum_o, 7);

    // 6: reset during WAIT, late done ignored, full hold-off afterwards
    pulse_start();
    wait_meas(300, got);
    check("t6_meas", got, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t6_meas_in_reset", measure_o, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    c0 = meas_cnt;
    send_frame(8'd9, 8'd9, 8'd9, 8'd9, 8'd36);
    idle(3);
    check("t6_valid", valid_o, 0);
    check("t6_hum", hum_o, 0);
    check("t6_stat", stat_o, 0);
    check("t6_ready", ready_o, 0);
    pulse_start();
    wait_meas(300, got);
    check("t6_meas_after", got, 1);
    check("t6_full_gap", last_meas >= 100, 1);
    check("t6_single", meas_cnt - c0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
